// File: rtl/ssp_pkg.sv
// Shared types and constants for the SSP master: FSM states, frame layout,
// counter sizing and target register addresses.
package ssp_pkg;

    localparam int SSP_FRAME_W = 16;
    localparam int SSP_CNT_W   = $clog2(256);

    localparam logic [2:0] SSP_RA_UCR = 3'b000;
    localparam logic [2:0] SSP_RA_USR = 3'b001;
    localparam logic [2:0] SSP_RA_TDR = 3'b010;
    localparam logic [2:0] SSP_RA_RDR = 3'b011;
    localparam logic [2:0] SSP_RA_SPR = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } ssp_state_e;

    typedef struct packed {
        logic [2:0]  ra;
        logic        wnr;
        logic [11:0] data;
    } ssp_frame_t;

    function automatic ssp_frame_t ssp_make_frame(input logic [2:0] ra, input logic wnr,
                                                  input logic [11:0] data);
        ssp_frame_t f;
        f.ra   = ra;
        f.wnr  = wnr;
        f.data = data;
        return f;
    endfunction

endpackage

// File: rtl/ssp_master_if.sv
// Host-side request/response bundle of the SSP master.
// The master modport is the host; the slave modport is the ssp_master block.
interface ssp_master_if;
    logic        Req;
    logic [2:0]  RA;
    logic        WnR;
    logic [11:0] WrData;
    logic        Busy;
    logic        Ack;
    logic [11:0] RdData;

    modport master (output Req, RA, WnR, WrData, input Busy, Ack, RdData);
    modport slave  (input Req, RA, WnR, WrData, output Busy, Ack, RdData);
endinterface

// File: rtl/ssp_sck_gen.sv
// Half-period timebase: pulses half_tick once every pSCK_Div Clk cycles while
// enabled; restart re-aligns the count to a new frame.
module ssp_sck_gen
    import ssp_pkg::*;
#(
    parameter int pSCK_Div = 4
) (
    input  logic Clk,
    input  logic Rst,
    input  logic restart,
    input  logic en,
    output logic half_tick
);

    localparam logic [SSP_CNT_W-1:0] C_RELOAD = SSP_CNT_W'(pSCK_Div - 1);

    logic [SSP_CNT_W-1:0] cnt_r;

    assign half_tick = en && (cnt_r == {SSP_CNT_W{1'b0}});

    // Down-counter reloading at every half-period boundary
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt_r <= {SSP_CNT_W{1'b0}};
        end else if (restart) begin
            cnt_r <= C_RELOAD;
        end else if (half_tick) begin
            cnt_r <= C_RELOAD;
        end else if (en) begin
            cnt_r <= cnt_r - {{(SSP_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/ssp_master.sv
// SSP master: shifts a 16-bit {RA, WnR, WrData} frame out MSB first and
// captures 12 bits of read data. Define SSP_MASTER_LOOPBACK_EN to sample MOSI as MISO.
module ssp_master
    import ssp_pkg::*;
#(
    parameter int pSCK_Div = 4,
    parameter int pGap     = 2
) (
    input  logic          Clk,
    input  logic          Rst,
    ssp_master_if.slave   host,
    output logic          SSP_SSEL,
    output logic          SSP_SCK,
    output logic          SSP_MOSI,
    input  logic          SSP_MISO
);

    localparam bit         C_HAS_GAP  = (pGap > 0);
    localparam logic [3:0] C_GAP_LOAD = 4'((pGap > 0) ? (pGap - 1) : 0);

    ssp_state_e  state_r;
    logic [14:0] tx_r;
    logic [11:0] rx_r;
    logic [3:0]  bit_cnt_r;
    logic [3:0]  gap_cnt_r;
    logic        busy_r;
    logic        ack_r;
    logic [11:0] rd_data_r;
    logic        ssel_r;
    logic        sck_r;
    logic        mosi_r;

    ssp_frame_t  frame_s;
    logic        start_s;
    logic        run_s;
    logic        tick_s;
    logic        miso_s;

`ifdef SSP_MASTER_LOOPBACK_EN
    logic miso_unused_s;
    assign miso_unused_s = SSP_MISO;
    assign miso_s        = mosi_r;
`else
    assign miso_s        = SSP_MISO;
`endif

    assign frame_s = ssp_make_frame(host.RA, host.WnR, host.WrData);

    // Decode request acceptance and the phases during which the timebase runs
    always_comb begin
        start_s = 1'b0;
        run_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                start_s = host.Req;
                run_s   = 1'b0;
            end
            ST_SETUP, ST_SHIFT, ST_HOLD: begin
                start_s = 1'b0;
                run_s   = 1'b1;
            end
            default: begin
                start_s = 1'b0;
                run_s   = 1'b0;
            end
        endcase
    end

    ssp_sck_gen #(.pSCK_Div(pSCK_Div)) u_sck_gen (
        .Clk       (Clk),
        .Rst       (Rst),
        .restart   (start_s),
        .en        (run_s),
        .half_tick (tick_s)
    );

    // Frame sequencer; every pin and host output is a register of this block
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_r   <= ST_IDLE;
            tx_r      <= 15'h0000;
            rx_r      <= 12'h000;
            bit_cnt_r <= 4'h0;
            gap_cnt_r <= 4'h0;
            busy_r    <= 1'b0;
            ack_r     <= 1'b0;
            rd_data_r <= 12'h000;
            ssel_r    <= 1'b0;
            sck_r     <= 1'b0;
            mosi_r    <= 1'b0;
        end else begin
            ack_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (host.Req) begin
                        tx_r      <= frame_s[14:0];
                        mosi_r    <= frame_s[15];
                        bit_cnt_r <= 4'hF;
                        busy_r    <= 1'b1;
                        ssel_r    <= 1'b1;
                        sck_r     <= 1'b0;
                        state_r   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tick_s) begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (tick_s) begin
                        if (!sck_r) begin
                            sck_r <= 1'b1;
                            rx_r  <= {rx_r[10:0], miso_s};
                        end else begin
                            sck_r <= 1'b0;
                            if (bit_cnt_r == 4'h0) begin
                                state_r <= ST_HOLD;
                            end else begin
                                bit_cnt_r <= bit_cnt_r - 4'h1;
                                mosi_r    <= tx_r[14];
                                tx_r      <= {tx_r[13:0], 1'b0};
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick_s) begin
                        ssel_r    <= 1'b0;
                        mosi_r    <= 1'b0;
                        ack_r     <= 1'b1;
                        rd_data_r <= rx_r;
                        if (C_HAS_GAP) begin
                            gap_cnt_r <= C_GAP_LOAD;
                            state_r   <= ST_GAP;
                        end else begin
                            busy_r  <= 1'b0;
                            state_r <= ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == 4'h0) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - 4'h1;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    ssel_r  <= 1'b0;
                    sck_r   <= 1'b0;
                    mosi_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign host.Busy   = busy_r;
    assign host.Ack    = ack_r;
    assign host.RdData = rd_data_r;
    assign SSP_SSEL    = ssel_r;
    assign SSP_SCK     = sck_r;
    assign SSP_MOSI    = mosi_r;

endmodule

// File: tb/tb_ssp_master.sv
// Directed bench for ssp_master at pSCK_Div=2, pGap=2 with a simple SSP slave model.
`timescale 1ns/1ps
module tb_ssp_master;

    localparam int C_DIV = 2;
    localparam int C_GAP = 2;
    localparam int C_LAT = 34 * C_DIV;
`ifdef SSP_MASTER_LOOPBACK_EN
    localparam bit C_LOOP = 1'b1;
`else
    localparam bit C_LOOP = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    logic ssel_s, sck_s, mosi_s;
    logic miso_r = 1'b0;

    ssp_master_if host();

    ssp_master #(.pSCK_Div(C_DIV), .pGap(C_GAP)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .host     (host),
        .SSP_SSEL (ssel_s),
        .SSP_SCK  (sck_s),
        .SSP_MOSI (mosi_s),
        .SSP_MISO (miso_r)
    );

    always #5 Clk = ~Clk;

    // Slave model and bus monitor, evaluated on the falling Clk edge
    logic [15:0] miso_word = 16'h0000;
    logic [15:0] mosi_cap  = 16'h0000;
    int          rise_cnt  = 0;
    int          ack_cnt   = 0;
    int          low_len   = 0;
    int          last_low_len = 0;
    logic        ssel_q = 1'b0;
    logic        sck_q  = 1'b0;

    always @(negedge Clk) begin
        ssel_q <= ssel_s;
        sck_q  <= sck_s;
        if (ssel_s && !ssel_q) begin
            rise_cnt     <= 0;
            mosi_cap     <= 16'h0000;
            last_low_len <= low_len;
            low_len      <= 0;
            miso_r       <= miso_word[15];
        end else if (!ssel_s) begin
            low_len <= low_len + 1;
        end
        if (sck_s && !sck_q) begin
            mosi_cap <= {mosi_cap[14:0], mosi_s};
            rise_cnt <= rise_cnt + 1;
            if (rise_cnt < 15) miso_r <= miso_word[14 - rise_cnt];
        end
        if (host.Ack) ack_cnt <= ack_cnt + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [11:0] exp_rd(input logic [11:0] wr, input logic [15:0] word);
        return C_LOOP ? wr : word[11:0];
    endfunction

    // Present a request for one edge, then scramble the inputs
    task automatic send(input logic [2:0] ra, input logic wnr, input logic [11:0] data);
        @(negedge Clk);
        host.Req = 1'b1; host.RA = ra; host.WnR = wnr; host.WrData = data;
        @(posedge Clk); #1;
        host.Req = 1'b0; host.RA = ~ra; host.WnR = ~wnr; host.WrData = ~data;
    endtask

    task automatic wait_ack(output int lat);
        lat = -1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge Clk); #1;
            if (host.Ack) begin
                lat = i;
                break;
            end
        end
    endtask

    int lat;
    int acks0;
    int n;

    initial begin
        host.Req = 1'b0; host.RA = 3'b000; host.WnR = 1'b0; host.WrData = 12'h000;
        miso_word = 16'h0FFF;
        repeat (3) @(posedge Clk); #1;
        check_eq("reset_ctrl", {27'd0, host.Busy, host.Ack, ssel_s, sck_s, mosi_s}, 32'd0);
        check_eq("reset_rddata", {20'd0, host.RdData}, 32'd0);
        @(negedge Clk); Rst = 1'b1;
        repeat (2) @(posedge Clk);

        // Write RA=0, WrData=C05
        send(3'b000, 1'b1, 12'hC05);
        check_eq("start_busy_ssel", {30'd0, host.Busy, ssel_s}, 32'd3);
        check_eq("start_mosi_sck", {30'd0, mosi_s, sck_s}, 32'd0);
        wait_ack(lat);
        check_eq("wr_latency", lat, C_LAT);
        check_eq("wr_mosi", {16'd0, mosi_cap}, 32'h1C05);
        check_eq("wr_rises", rise_cnt, 32'd16);
        check_eq("wr_rddata", {20'd0, host.RdData}, {20'd0, exp_rd(12'hC05, 16'h0FFF)});
        check_eq("wr_ssel_at_ack", {31'd0, ssel_s}, 32'd0);
        check_eq("wr_busy_at_ack", {31'd0, host.Busy}, 32'd1);
        @(posedge Clk); #1;
        check_eq("ack_pulse", {30'd0, host.Ack, host.Busy}, 32'd1);
        @(posedge Clk); #1;
        check_eq("gap_end_busy", {31'd0, host.Busy}, 32'd0);

        // Read RA=3 with slave returning A5A
        miso_word = 16'h3A5A;
        send(3'b011, 1'b0, 12'h3C3);
        wait_ack(lat);
        check_eq("rd_latency", lat, C_LAT);
        check_eq("rd_mosi", {16'd0, mosi_cap}, 32'h63C3);
        check_eq("rd_rddata", {20'd0, host.RdData}, {20'd0, exp_rd(12'h3C3, 16'h3A5A)});
        check_eq("rd_ssel_at_ack", {31'd0, ssel_s}, 32'd0);
        repeat (10) @(posedge Clk); #1;
        check_eq("rd_hold", {20'd0, host.RdData}, {20'd0, exp_rd(12'h3C3, 16'h3A5A)});

        // Second request in the middle of SHIFT is dropped
        acks0 = ack_cnt;
        miso_word = 16'h1234;
        send(3'b010, 1'b1, 12'h5A1);
        repeat (20) @(posedge Clk);
        @(negedge Clk);
        host.Req = 1'b1; host.RA = 3'b111; host.WrData = 12'hFFF;
        @(negedge Clk);
        host.Req = 1'b0;
        wait_ack(lat);
        check_eq("busyreq_ack_seen", {31'd0, lat > 0}, 32'd1);
        check_eq("busyreq_mosi", {16'd0, mosi_cap}, 32'h55A1);
        check_eq("busyreq_rddata", {20'd0, host.RdData}, {20'd0, exp_rd(12'h5A1, 16'h1234)});
        repeat (100) @(posedge Clk); #1;
        check_eq("busyreq_one_ack", ack_cnt - acks0, 32'd1);
        check_eq("busyreq_idle", {30'd0, host.Busy, ssel_s}, 32'd0);

        // Req held high: back-to-back frames separated by gap plus one idle cycle
        acks0 = ack_cnt;
        miso_word = 16'hF0F0;
        @(negedge Clk);
        host.Req = 1'b1; host.RA = 3'b001; host.WnR = 1'b1; host.WrData = 12'h0AB;
        @(posedge Clk); #1;
        check_eq("hold_accept", {31'd0, ssel_s}, 32'd1);
        wait_ack(lat);
        check_eq("hold_latency1", lat, C_LAT);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge Clk); #1;
            if (ssel_s) begin
                n = i;
                break;
            end
        end
        check_eq("hold_restart_cycles", n, 32'd3);
        wait_ack(lat);
        host.Req = 1'b0;
        check_eq("hold_latency2", lat, C_LAT);
        check_eq("hold_ssel_low_len", last_low_len, 32'd3);
        check_eq("hold_mosi2", {16'd0, mosi_cap}, 32'h30AB);
        check_eq("hold_rddata", {20'd0, host.RdData}, {20'd0, exp_rd(12'h0AB, 16'hF0F0)});
        repeat (100) @(posedge Clk); #1;
        check_eq("hold_two_acks", ack_cnt - acks0, 32'd2);

        // Reset during bit 7 aborts the frame
        miso_word = 16'h0ABC;
        send(3'b100, 1'b1, 12'h777);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge Clk); #1;
            if (rise_cnt == 9) begin
                n = 1;
                break;
            end
        end
        check_eq("rst_reached_bit7", n, 32'd1);
        @(negedge Clk);
        acks0 = ack_cnt;
        Rst = 1'b0;
        #1;
        check_eq("rst_ctrl", {27'd0, host.Busy, host.Ack, ssel_s, sck_s, mosi_s}, 32'd0);
        check_eq("rst_rddata", {20'd0, host.RdData}, 32'd0);
        repeat (5) @(posedge Clk);
        @(negedge Clk); Rst = 1'b1;
        repeat (80) @(posedge Clk); #1;
        check_eq("rst_no_ack", ack_cnt - acks0, 32'd0);
        check_eq("rst_idle", {30'd0, host.Busy, ssel_s}, 32'd0);
        send(3'b101, 1'b1, 12'h9E4);
        wait_ack(lat);
        check_eq("post_rst_latency", lat, C_LAT);
        check_eq("post_rst_mosi", {16'd0, mosi_cap}, 32'hB9E4);
        check_eq("post_rst_rddata", {20'd0, host.RdData}, {20'd0, exp_rd(12'h9E4, 16'h0ABC)});

        repeat (5) @(posedge Clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
